// File: rtl/comparador_pkg.sv
// Shared definitions for the comparator family: FSM state encoding and
// the default operand width.
package comparador_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        COMPARA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    localparam int COMPARADOR_N_PADRAO = 8;

endpackage

// File: rtl/comparador1bit.sv
// Single-bit magnitude compare cell. The enable input is the equal-chain
// from the more significant bits: once a difference has been found the
// cell is disabled and all three outputs are forced low.
module comparador1bit (
    input  logic en,
    input  logic a,
    input  logic b,
    output logic maior,
    output logic menor,
    output logic igual
);

    assign maior = en & a & ~b;
    assign menor = en & ~a & b;
    assign igual = en & ~(a ^ b);

endmodule

// File: rtl/comparador_serial.sv
// Serial magnitude comparator: walks one comparador1bit cell over the
// captured operands MSB-first, one bit per clock, and reports
// igual/maior/menor with a one-cycle pronto pulse.
// Optional feature macro: COMPARADOR_SERIAL_EARLY_EXIT_EN -- when defined,
// the scan stops on the first differing bit instead of running all N bits.
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int N = COMPARADOR_N_PADRAO
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inicio,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ocupado,
    output logic         pronto,
    output logic         igual,
    output logic         maior,
    output logic         menor
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    estado_t          estado_r;
    estado_t          estado_prox_s;
    logic [N-1:0]     a_r;
    logic [N-1:0]     b_r;
    logic [IDX_W-1:0] idx_r;
    logic             cadeia_r;
    logic             maior_flag_r;
    logic             menor_flag_r;
    logic             ocupado_r;
    logic             pronto_r;
    logic             igual_r;
    logic             maior_r;
    logic             menor_r;
    logic             bit_a_s;
    logic             bit_b_s;
    logic             cel_maior_s;
    logic             cel_menor_s;
    logic             cel_igual_s;

    assign bit_a_s = a_r[idx_r];
    assign bit_b_s = b_r[idx_r];

    comparador1bit u_celula (
        .en    (cadeia_r),
        .a     (bit_a_s),
        .b     (bit_b_s),
        .maior (cel_maior_s),
        .menor (cel_menor_s),
        .igual (cel_igual_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r <= OCIOSO;
        end else begin
            estado_r <= estado_prox_s;
        end
    end

    // Next-state logic: idle until a start request, scan, then one result cycle.
    always_comb begin
        estado_prox_s = estado_r;
        case (estado_r)
            OCIOSO: begin
                if (inicio) begin
                    estado_prox_s = COMPARA;
                end else begin
                    estado_prox_s = OCIOSO;
                end
            end
            COMPARA: begin
`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
                // The chain is always 1 on entry to a bit here, so a low cell
                // igual output means this bit is the first difference.
                if ((idx_r == IDX_ZERO) || !cel_igual_s) begin
                    estado_prox_s = FIM;
                end else begin
                    estado_prox_s = COMPARA;
                end
`else
                if (idx_r == IDX_ZERO) begin
                    estado_prox_s = FIM;
                end else begin
                    estado_prox_s = COMPARA;
                end
`endif
            end
            FIM:     estado_prox_s = OCIOSO;
            default: estado_prox_s = OCIOSO;
        endcase
    end

    // Datapath: operand capture, index/chain/flag updates and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r          <= {N{1'b0}};
            b_r          <= {N{1'b0}};
            idx_r        <= IDX_ZERO;
            cadeia_r     <= 1'b0;
            maior_flag_r <= 1'b0;
            menor_flag_r <= 1'b0;
            ocupado_r    <= 1'b0;
            pronto_r     <= 1'b0;
            igual_r      <= 1'b0;
            maior_r      <= 1'b0;
            menor_r      <= 1'b0;
        end else begin
            case (estado_r)
                OCIOSO: begin
                    if (inicio) begin
                        a_r          <= A;
                        b_r          <= B;
                        idx_r        <= IDX_MSB;
                        cadeia_r     <= 1'b1;
                        maior_flag_r <= 1'b0;
                        menor_flag_r <= 1'b0;
                        igual_r      <= 1'b0;
                        maior_r      <= 1'b0;
                        menor_r      <= 1'b0;
                        ocupado_r    <= 1'b1;
                    end
                end
                COMPARA: begin
                    cadeia_r     <= cel_igual_s;
                    maior_flag_r <= maior_flag_r | cel_maior_s;
                    menor_flag_r <= menor_flag_r | cel_menor_s;
                    idx_r        <= idx_r - IDX_W'(1);
                    if (estado_prox_s == FIM) begin
                        pronto_r <= 1'b1;
                        igual_r  <= cel_igual_s;
                        maior_r  <= maior_flag_r | cel_maior_s;
                        menor_r  <= menor_flag_r | cel_menor_s;
                    end
                end
                FIM: begin
                    pronto_r  <= 1'b0;
                    ocupado_r <= 1'b0;
                end
                default: begin
                    pronto_r  <= 1'b0;
                    ocupado_r <= 1'b0;
                end
            endcase
        end
    end

    assign ocupado = ocupado_r;
    assign pronto  = pronto_r;
    assign igual   = igual_r;
    assign maior   = maior_r;
    assign menor   = menor_r;

endmodule

// File: doc/comparador_serial.md
# comparador_serial

Sequential magnitude comparator controller. It accepts two N-bit unsigned operands with a start pulse, then walks a single 1-bit compare cell across them MSB-first, one bit per clock. It reports `igual`/`maior`/`menor` with a one-cycle `pronto` pulse. It sits beside the combinational comparator family as the area-cheap variant for wide operands, driven by a start/done handshake from the surrounding control logic.

## Interface
- `N`, default 8: operand width in bits; legal range N ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `inicio` input 1: start request; sampled only in state OCIOSO.
- `A` input N: operand A, unsigned; captured on the accepting edge.
- `B` input N: operand B, unsigned; captured on the accepting edge.
- `ocupado` output 1: high while in COMPARA or FIM.
- `pronto` output 1: one-cycle pulse; results valid.
- `igual` output 1: A == B.
- `maior` output 1: A > B.
- `menor` output 1: A < B.

## Operation
- Reset values: state OCIOSO, `ocupado`=0, `pronto`=0, `igual`=0, `maior`=0, `menor`=0, index=0, operand registers 0.
- State OCIOSO:
  - `inicio`=1 at an edge latches A and B.
  - Sets index=N-1 and the internal equal-chain=1.
  - Clears `igual`/`maior`/`menor`.
  - Moves to COMPARA.
- State COMPARA, one bit per edge, at index i:
  - The cell is enabled by the equal-chain.
  - A[i]=1, B[i]=0 sets the `maior` flag and clears the chain.
  - A[i]=0, B[i]=1 sets the `menor` flag and clears the chain.
  - Equal bits leave the chain at 1.
  - Index decrements.
  - At i=0, go to FIM.
- State FIM, one cycle:
  - `pronto`=1.
  - `igual` = final chain value; `maior`/`menor` hold the latched flags.
  - Next edge goes to OCIOSO.
- Result outputs hold their values after FIM until the next accepted `inicio`.
- Exactly one of `igual`/`maior`/`menor` is 1 whenever `pronto`=1.
- Ignored requests: `inicio` in COMPARA or FIM is dropped (not queued). A/B changes after capture have no effect.
- Reset mid-operation: the next edge returns to OCIOSO with all outputs at their reset values. No `pronto` is issued for the aborted compare.
- Index register width is $clog2(N).

## Timing
- Edge k accepts `inicio`. Edges k+1 .. k+N process bits N-1 .. 0.
- Without the early-exit feature, `pronto` is high in the cycle after edge k+N: latency N cycles for every operand pair.
- Back-to-back operation:
  - `inicio` held high through FIM is accepted at the first edge in OCIOSO, i.e. edge k+N+2.
  - Throughput is one compare per N+2 cycles.
- `ocupado` is high from the cycle after edge k through the FIM cycle inclusive.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

## Configuration
- Macro: `COMPARADOR_SERIAL_EARLY_EXIT_EN`.
- Defined:
  - COMPARA moves to FIM on the edge that finds the first differing bit.
  - Latency for a first difference at bit i is N-i cycles.
  - Equal operands still take N cycles.
- Undefined:
  - The scan always runs all N bits.
  - Once the chain is 0, later bits are disabled and change nothing.
  - Fixed N-cycle latency.
- Results are identical in both builds; only latency differs.

## Structure
- Shared package `comparador_pkg`:
  - state enumeration (OCIOSO, COMPARA, FIM) with a 2-bit encoding;
  - default width constant `COMPARADOR_N_PADRAO` = 8.
- One sub-module is natural: `comparador1bit`, the single-bit cell.
  - Ports: enable/chain-in, a, b, maior, menor, igual.
  - Instantiated once and fed A[index]/B[index].
- FSM, index counter and result registers live in `comparador_serial`.

## Test plan
- N=8, A=0x5A, B=0x5A, `inicio` pulse → `pronto` 8 cycles later; `igual`=1, `maior`=0, `menor`=0.
- A=0x80, B=0x7F → `maior`=1. Latency 1 with `COMPARADOR_SERIAL_EARLY_EXIT_EN` defined, 8 without.
- A=0x12, B=0x13 → `menor`=1 with latency 8 in both builds; outputs hold after `pronto` drops.
- Start A=0xFF, B=0x00; pulse `inicio` with A=0x00, B=0xFF during COMPARA → the second request is ignored; the single `pronto` reports `maior`=1.
- Assert `rst` at cycle 3 of a compare → next cycle `ocupado`=0 and all flags 0; no `pronto` appears afterwards.
- `inicio` held high continuously with alternating operands → a new compare is accepted every N+2 cycles; each `pronto` is correct for its captured operands.
